// File: rtl/lenet_result_rd_fifo_pkg.sv
// Shared types and constants for the LeNet result read FIFO.
package lenet_xfer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StEof
  } xfer_state_e;

  localparam int unsigned LENET_DATA_W = 32;
  localparam int unsigned FRAME_CNT_W  = 16;
  localparam int unsigned WORD_CNT_W   = 32;

endpackage

// File: rtl/lenet_result_rd_fifo_if.sv
// Accelerator result stream plus Xillybus read_32 FIFO signals.
// The slave modport is the FIFO side.
interface lenet_result_rd_fifo_if;

  logic                                   in_valid;
  logic [lenet_xfer_pkg::LENET_DATA_W-1:0] in_data;
  logic                                   in_last;
  logic                                   in_ready;
  logic                                   user_r_read_32_rden;
  logic [lenet_xfer_pkg::LENET_DATA_W-1:0] user_r_read_32_data;
  logic                                   user_r_read_32_empty;
  logic                                   user_r_read_32_eof;
  logic                                   user_r_read_32_open;

  modport master (
    output in_valid, in_data, in_last, user_r_read_32_rden, user_r_read_32_open,
    input  in_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof
  );

  modport slave (
    input  in_valid, in_data, in_last, user_r_read_32_rden, user_r_read_32_open,
    output in_ready, user_r_read_32_data, user_r_read_32_empty, user_r_read_32_eof
  );

endinterface

// File: rtl/lenet_sync_fifo_mem.sv
// Simple dual-port storage: one write port, one registered read port.
module lenet_sync_fifo_mem #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register holds its value between reads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lenet_result_rd_fifo.sv
// Frame-aware result FIFO feeding the Xillybus read_32 stream.
// Define LENET_RESULT_FIFO_STATS_EN to add frame_count/word_count outputs.
module lenet_result_rd_fifo
  import lenet_xfer_pkg::*;
#(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DATA_W = LENET_DATA_W
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst_n,
  lenet_result_rd_fifo_if.slave  bus,
  output logic [ADDR_W:0]        fill_level
`ifdef LENET_RESULT_FIFO_STATS_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [WORD_CNT_W-1:0]  word_count
`endif
);

  localparam logic [ADDR_W:0] PtrOne  = 1;
  localparam logic [ADDR_W:0] FullXor = {1'b1, {ADDR_W{1'b0}}};

  xfer_state_e     state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;

  logic full, ptr_eq, empty, in_ready, wr_acc, rd_acc, open;

  assign open     = bus.user_r_read_32_open;
  assign ptr_eq   = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == FullXor);
  assign empty    = ptr_eq | (state_q == StEof);
  assign in_ready = (state_q == StStream) & ~full;
  assign wr_acc   = bus.in_valid & in_ready;
  assign rd_acc   = bus.user_r_read_32_rden & ~empty;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PtrOne;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PtrOne;
    unique case (state_q)
      StIdle:   if (open) state_d = StStream;
      StStream: if (wr_acc && bus.in_last) state_d = StDrain;
      // Frame ends once the read that takes the last word has been accepted.
      StDrain:  if (rd_ptr_d == wr_ptr_d) state_d = StEof;
      StEof:    state_d = StEof;
      default:  state_d = StIdle;
    endcase
    // Close wins over everything: flush stored and in-flight words.
    if (!open) begin
      state_d  = StIdle;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  lenet_sync_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i     (bus_clk),
    .rst_ni    (bus_rst_n),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (bus.in_data),
    .rd_en_i   (rd_acc),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (bus.user_r_read_32_data)
  );

  assign bus.in_ready             = in_ready;
  assign bus.user_r_read_32_empty = empty;
  assign bus.user_r_read_32_eof   = (state_q == StEof);
  assign fill_level               = wr_ptr_q - rd_ptr_q;

`ifdef LENET_RESULT_FIFO_STATS_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [WORD_CNT_W-1:0]  word_cnt_q;

  // Cleared by reset only; a close leaves the totals intact.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      frame_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else begin
      if (state_q == StStream && state_d == StDrain) frame_cnt_q <= frame_cnt_q + 1'b1;
      if (rd_acc) word_cnt_q <= word_cnt_q + 1'b1;
    end
  end

  assign frame_count = frame_cnt_q;
  assign word_count  = word_cnt_q;
`endif

endmodule

// File: tb/tb_lenet_result_rd_fifo.sv
// Self-checking bench for lenet_result_rd_fifo: cycle vector table plus directed sequences.
module tb_lenet_result_rd_fifo;

  localparam int unsigned DEPTH  = 512;
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic            bus_clk;
  logic            bus_rst_n;
  logic [ADDR_W:0] fill_level;
`ifdef LENET_RESULT_FIFO_STATS_EN
  logic [15:0]     frame_count;
  logic [31:0]     word_count;
`endif

  lenet_result_rd_fifo_if u_if ();

  lenet_result_rd_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (32)
  ) dut (
    .bus_clk    (bus_clk),
    .bus_rst_n  (bus_rst_n),
    .bus        (u_if),
    .fill_level (fill_level)
`ifdef LENET_RESULT_FIFO_STATS_EN
    ,
    .frame_count (frame_count),
    .word_count  (word_count)
`endif
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  typedef struct {
    logic        open;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_last;
    logic        rden;
    logic        exp_ready;
    logic        exp_empty;
    logic        exp_eof;
    int          exp_level;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] sb [$];
  logic [31:0] exp_data;
  int          n_checks;
  int          n_fail;
  logic        pre_ready;
  logic        pre_empty;

  function automatic vec_t mk(logic op, logic v, logic [31:0] d, logic l, logic r,
                              logic er, logic ee, logic ef, int el);
    vec_t t;
    t.open = op; t.in_valid = v; t.in_data = d; t.in_last = l; t.rden = r;
    t.exp_ready = er; t.exp_empty = ee; t.exp_eof = ef; t.exp_level = el;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_underflow: got 0 entries, expected at least 1");
    end else begin
      exp_data = sb.pop_front();
    end
  endtask

  task automatic wr(input logic [31:0] d, input logic last);
    chk("wr_ready", {31'b0, u_if.in_ready}, 32'd1);
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    u_if.in_last  = last;
    sb.push_back(d);
    cyc();
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
  endtask

  task automatic rd();
    chk("rd_nonempty", {31'b0, u_if.user_r_read_32_empty}, 32'd0);
    u_if.user_r_read_32_rden = 1'b1;
    pop_exp();
    cyc();
    u_if.user_r_read_32_rden = 1'b0;
    chk("rd_data", u_if.user_r_read_32_data, exp_data);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ready"}, {31'b0, u_if.in_ready}, 32'd0);
    chk({nm, "_empty"}, {31'b0, u_if.user_r_read_32_empty}, 32'd1);
    chk({nm, "_eof"}, {31'b0, u_if.user_r_read_32_eof}, 32'd0);
    chk({nm, "_data"}, u_if.user_r_read_32_data, 32'd0);
    chk({nm, "_level"}, 32'(fill_level), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_data = '0;
    bus_rst_n = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = '0;
    u_if.in_last  = 1'b0;
    u_if.user_r_read_32_rden = 1'b0;
    u_if.user_r_read_32_open = 1'b0;

    // open, valid, data, last, rden | ready, empty, eof, level after the edge
    tbl[0]  = mk(1, 0, 32'h0, 0, 0, 1, 1, 0, 0);
    tbl[1]  = mk(1, 1, 32'hA, 0, 0, 1, 0, 0, 1);
    tbl[2]  = mk(1, 1, 32'hB, 0, 0, 1, 0, 0, 2);
    tbl[3]  = mk(1, 1, 32'hC, 1, 0, 0, 0, 0, 3);
    tbl[4]  = mk(1, 0, 32'h0, 0, 1, 0, 0, 0, 2);
    tbl[5]  = mk(1, 0, 32'h0, 0, 1, 0, 0, 0, 1);
    tbl[6]  = mk(1, 0, 32'h0, 0, 1, 0, 1, 1, 0);
    tbl[7]  = mk(1, 0, 32'h0, 0, 1, 0, 1, 1, 0);
    tbl[8]  = mk(0, 0, 32'h0, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(1, 0, 32'h0, 0, 0, 1, 1, 0, 0);
    for (int i = 10; i < 15; i++) tbl[i] = mk(1, 0, 32'h0, 0, 1, 1, 1, 0, 0);

    repeat (3) cyc();
    chk_reset_vals("reset");
    bus_rst_n = 1'b1;
    cyc();
    chk_reset_vals("post_reset");

    // Frame of three words, then empty-read hammering.
    pre_ready = 1'b0;
    pre_empty = 1'b1;
    for (int i = 0; i < 15; i++) begin
      u_if.user_r_read_32_open = tbl[i].open;
      u_if.in_valid            = tbl[i].in_valid;
      u_if.in_data             = tbl[i].in_data;
      u_if.in_last             = tbl[i].in_last;
      u_if.user_r_read_32_rden = tbl[i].rden;
      if (tbl[i].in_valid && pre_ready) sb.push_back(tbl[i].in_data);
      if (tbl[i].rden && !pre_empty) pop_exp();
      cyc();
      chk($sformatf("tbl%0d_ready", i), {31'b0, u_if.in_ready}, {31'b0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_empty", i), {31'b0, u_if.user_r_read_32_empty},
          {31'b0, tbl[i].exp_empty});
      chk($sformatf("tbl%0d_eof", i), {31'b0, u_if.user_r_read_32_eof}, {31'b0, tbl[i].exp_eof});
      chk($sformatf("tbl%0d_level", i), 32'(fill_level), 32'(tbl[i].exp_level));
      chk($sformatf("tbl%0d_data", i), u_if.user_r_read_32_data, exp_data);
      pre_ready = tbl[i].exp_ready;
      pre_empty = tbl[i].exp_empty;
    end
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
    u_if.user_r_read_32_rden = 1'b0;

    // Fill to DEPTH, then one read frees exactly one slot for the held word.
    for (int i = 0; i < int'(DEPTH); i++) wr(32'h1000 + 32'(i), 1'b0);
    chk("full_level", 32'(fill_level), DEPTH);
    chk("full_ready", {31'b0, u_if.in_ready}, 32'd0);
    u_if.in_valid = 1'b1;
    u_if.in_data  = 32'h2000;
    u_if.user_r_read_32_rden = 1'b1;
    pop_exp();
    cyc();
    u_if.user_r_read_32_rden = 1'b0;
    chk("full_rd_data", u_if.user_r_read_32_data, exp_data);
    chk("full_rd_level", 32'(fill_level), DEPTH - 1);
    chk("full_rd_ready", {31'b0, u_if.in_ready}, 32'd1);
    sb.push_back(32'h2000);
    cyc();
    chk("refill_level", 32'(fill_level), DEPTH);
    chk("refill_ready", {31'b0, u_if.in_ready}, 32'd0);
    cyc();
    chk("hold_level", 32'(fill_level), DEPTH);
    u_if.in_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) rd();
    chk("drained_level", 32'(fill_level), 32'd0);

    // Close mid-stream flushes everything; reopen starts clean.
    for (int i = 0; i < 10; i++) wr(32'h3000 + 32'(i), 1'b0);
    for (int i = 0; i < 4; i++) rd();
    u_if.user_r_read_32_open = 1'b0;
    cyc();
    chk("close_level", 32'(fill_level), 32'd0);
    chk("close_empty", {31'b0, u_if.user_r_read_32_empty}, 32'd1);
    chk("close_eof", {31'b0, u_if.user_r_read_32_eof}, 32'd0);
    chk("close_ready", {31'b0, u_if.in_ready}, 32'd0);
    sb.delete();
    u_if.user_r_read_32_open = 1'b1;
    cyc();
    wr(32'h55, 1'b0);
    rd();

    // Simultaneous write and read at level 1.
    wr(32'h300, 1'b0);
    for (int k = 0; k < 100; k++) begin
      u_if.in_valid = 1'b1;
      u_if.in_data  = 32'h301 + 32'(k);
      u_if.user_r_read_32_rden = 1'b1;
      pop_exp();
      sb.push_back(32'h301 + 32'(k));
      cyc();
      chk($sformatf("simul%0d_data", k), u_if.user_r_read_32_data, exp_data);
      chk($sformatf("simul%0d_level", k), 32'(fill_level), 32'd1);
    end
    u_if.in_valid = 1'b0;
    u_if.user_r_read_32_rden = 1'b0;

    // Asynchronous reset while draining a frame.
    wr(32'h400, 1'b1);
    chk("drain_ready", {31'b0, u_if.in_ready}, 32'd0);
    chk("drain_level", 32'(fill_level), 32'd2);
`ifdef LENET_RESULT_FIFO_STATS_EN
    chk("stats_frames", 32'(frame_count), 32'd2);
`endif
    #2;
    bus_rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
`ifdef LENET_RESULT_FIFO_STATS_EN
    chk("midreset_frames", 32'(frame_count), 32'd0);
    chk("midreset_words", word_count, 32'd0);
`endif
    sb.delete();
    exp_data = '0;
    cyc();
    cyc();
    bus_rst_n = 1'b1;
    cyc();
    chk("after_reset_ready", {31'b0, u_if.in_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lenet_result_rd_fifo.md
Name: lenet_result_rd_fifo

Overview:
Buffers 32-bit classification results from the LeNet5 accelerator output stage and presents them on the Xillybus `user_r_read_32_*` FIFO interface. It sits directly upstream of xillybus_core's read_32 stream.
- Adds frame-aware EOF signalling: the host read returns EOF once a frame's last word has been drained.
- Flushes all buffered state whenever the host closes the device file.

Parameters:
DEPTH, 512, storage words; power of two, minimum 4
ADDR_W, $clog2(DEPTH), pointer index width
DATA_W, 32, data word width; fixed to match read_32

Ports:
bus_clk  input  1  single system clock (Xillybus bus clock)
bus_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  accelerator result word valid
in_data  input  DATA_W  accelerator result word
in_last  input  1  marks the last word of a frame; qualified by in_valid
in_ready  output  1  block accepts the word this cycle
user_r_read_32_rden  input  1  read strobe from xillybus_core
user_r_read_32_data  output  DATA_W  read data, valid the cycle after an accepted rden
user_r_read_32_empty  output  1  no word available for reading
user_r_read_32_eof  output  1  end of frame reached; host read returns EOF
user_r_read_32_open  input  1  host has the device file open
fill_level  output  ADDR_W+1  words currently stored

Behaviour:
- Reset (bus_rst_n=0, asynchronous):
  - pointers=0, fill_level=0, state=IDLE.
  - in_ready=0, empty=1, eof=0, data=0.
- Storage and pointers:
  - Pointers are ADDR_W+1 bits and wrap naturally.
  - full when (wr_ptr^rd_ptr)=={1'b1,0...}; empty when wr_ptr==rd_ptr.
  - fill_level=wr_ptr-rd_ptr, modulo 2^(ADDR_W+1).
- Write accept: wr_acc = in_valid & in_ready.
  - in_ready=1 only in state STREAM and !full.
  - in_ready is combinational from registered state/pointers.
- Read accept: rd_acc = rden & !empty.
  - rden while empty is ignored: no pointer move, data holds.
  - user_r_read_32_data is registered and updates one cycle after rd_acc (standard FIFO, not FWFT).
- Empty flag: user_r_read_32_empty is combinational from registered pointers.
  - A write into an empty FIFO clears empty on the next cycle.
- Simultaneous wr_acc and rd_acc:
  - Both proceed and fill_level is unchanged.
  - At full, in_ready is already 0, so the write cannot occur that cycle.
- States:
  - IDLE: open=0. Pointers are forced equal (flush), in_ready=0, eof=0. Go to STREAM when open=1.
  - STREAM: normal operation. If wr_acc with in_last=1, go to DRAIN.
  - DRAIN: in_ready=0. Go to EOF when the FIFO becomes empty, i.e. the last word has been read by rd_acc.
  - EOF: eof=1 and empty=1, held until open=0.
- Open deasserted in any state: go to IDLE next cycle and flush stored words. A partially written frame is discarded.
- Reset mid-operation: immediate return to reset values; no words are preserved.
- in_last on a word offered while in_ready=0 is not consumed; the accelerator must hold the word and its in_last.

Optional Feature:
LENET_RESULT_FIFO_STATS_EN
- Defined: adds outputs frame_count[15:0] and word_count[31:0].
  - frame_count increments on each STREAM->DRAIN transition.
  - word_count increments on each rd_acc.
  - Both cleared by reset only, not by close; both wrap.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lenet_xfer_pkg:
  - state enum {IDLE, STREAM, DRAIN, EOF}
  - LENET_DATA_W=32
  - counter width constants
- Sub-module lenet_sync_fifo_mem: simple dual-port RAM.
  - One write port, one registered read port; DEPTH x DATA_W.
  - Holds no flag logic.
- Top level: pointers, flags, FSM, optional stats.

Test Plan:
- Reset, then open=1; write 3 words 0xA,0xB,0xC (last on 0xC); rden each -> data 0xA,0xB,0xC one cycle after each rden; eof=1 after third read, empty=1.
- open=1, write DEPTH words with no last -> in_ready=0 at fill_level=DEPTH; one rden with in_valid held -> exactly one word accepted next cycle, level stays DEPTH.
- Empty FIFO, rden=1 for 5 cycles -> no pointer change, data holds previous value, level 0.
- Write 10 words, read 4, drop open -> next cycle level=0, empty=1, eof=0; reopen and write 0x55 -> first read returns 0x55.
- Simultaneous in_valid and rden with level=1 for 100 cycles -> level stays 1, data sequence matches written order.
- Assert bus_rst_n=0 mid-DRAIN -> all outputs at reset values in the same cycle; with STATS_EN, frame_count=0.
